// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: raster counters, scaled memory addressing, bank cycling
// and a two-stage output pipeline aligned with a one-clock-latency video memory.
module vga_scan_ctrl #(
  parameter int WIDTH        = 10,
  parameter int HEIGHT       = 20,
  parameter int H_VISIBLE    = 800,
  parameter int H_FRONT      = 40,
  parameter int H_SYNC       = 128,
  parameter int WHOLE_LINE   = 1056,
  parameter int V_VISIBLE    = 600,
  parameter int V_FRONT      = 1,
  parameter int V_SYNC       = 4,
  parameter int WHOLE_FRAME  = 628,
  parameter int SCALE        = 4,
  parameter int FRAME_REPEAT = 2,
  parameter int NUM_BANKS    = 16,
  localparam int X_ADDRW     = $clog2(WIDTH),
  localparam int Y_ADDRW     = $clog2(HEIGHT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_color,
  output logic [X_ADDRW-1:0] x_pos,
  output logic [Y_ADDRW-1:0] y_pos,
  output logic [3:0]         bank_counter,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               frame_start
);

  localparam int HW = $clog2(WHOLE_LINE + 1);
  localparam int VW = $clog2(WHOLE_FRAME + 1);
  localparam int SW = $clog2(SCALE + 1);
  localparam int FW = $clog2(FRAME_REPEAT + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(WHOLE_LINE - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_IMG   = HW'(WIDTH * SCALE);
  localparam logic [VW-1:0] V_LAST  = VW'(WHOLE_FRAME - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END  = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_IMG   = VW'(HEIGHT * SCALE);
  localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(FRAME_REPEAT - 1);
  localparam logic [3:0]    B_LAST  = 4'(NUM_BANKS - 1);
  localparam logic [X_ADDRW-1:0] X_LAST = X_ADDRW'(WIDTH - 1);
  localparam logic [Y_ADDRW-1:0] Y_LAST = Y_ADDRW'(HEIGHT - 1);

  if ((WIDTH * SCALE > H_VISIBLE) || (HEIGHT * SCALE > V_VISIBLE) ||
      (NUM_BANKS > 16) || (NUM_BANKS < 1)) begin : g_bad_params
    $error("vga_scan_ctrl: image does not fit visible area or NUM_BANKS out of 1..16");
  end

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic [SW-1:0] x_sub_r;
  logic [SW-1:0] y_sub_r;
  logic [FW-1:0] frame_cnt_r;
  logic          h_wrap_s, v_wrap_s;
  logic          hsync_s, vsync_s, video_s, image_s, start_s;
  logic          hsync_d1_r, vsync_d1_r, video_d1_r, image_d1_r, start_d1_r;

  // Raw timing decode from the current counter position.
  always_comb begin
    h_wrap_s = (h_cnt_r == H_LAST);
    v_wrap_s = (v_cnt_r == V_LAST);
    hsync_s  = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
    vsync_s  = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
    video_s  = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    image_s  = (h_cnt_r < H_IMG) && (v_cnt_r < V_IMG);
    start_s  = (h_cnt_r == HW'(0)) && (v_cnt_r == VW'(0));
  end

  // Raster counters, replicated addresses and frame/bank sequencing; the
  // address registers move in lockstep so x_pos/y_pos always match h/v.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r      <= HW'(0);
      v_cnt_r      <= VW'(0);
      x_sub_r      <= SW'(0);
      y_sub_r      <= SW'(0);
      x_pos        <= X_ADDRW'(0);
      y_pos        <= Y_ADDRW'(0);
      frame_cnt_r  <= FW'(0);
      bank_counter <= 4'h0;
    end else if (h_wrap_s) begin
      h_cnt_r <= HW'(0);
      x_sub_r <= SW'(0);
      x_pos   <= X_ADDRW'(0);
      if (v_wrap_s) begin
        v_cnt_r <= VW'(0);
        y_sub_r <= SW'(0);
        y_pos   <= Y_ADDRW'(0);
        if (frame_cnt_r == F_LAST) begin
          frame_cnt_r  <= FW'(0);
          bank_counter <= (bank_counter == B_LAST) ? 4'h0 : bank_counter + 4'h1;
        end else begin
          frame_cnt_r <= frame_cnt_r + FW'(1);
        end
      end else begin
        v_cnt_r <= v_cnt_r + VW'(1);
        if (y_sub_r == S_LAST) begin
          y_sub_r <= SW'(0);
          y_pos   <= (y_pos == Y_LAST) ? y_pos : y_pos + Y_ADDRW'(1);
        end else begin
          y_sub_r <= y_sub_r + SW'(1);
        end
      end
    end else begin
      h_cnt_r <= h_cnt_r + HW'(1);
      if (x_sub_r == S_LAST) begin
        x_sub_r <= SW'(0);
        x_pos   <= (x_pos == X_LAST) ? x_pos : x_pos + X_ADDRW'(1);
      end else begin
        x_sub_r <= x_sub_r + SW'(1);
      end
    end
  end

  // Stage 1: hold timing flags while the memory read is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_d1_r <= 1'b0;
      vsync_d1_r <= 1'b0;
      video_d1_r <= 1'b0;
      image_d1_r <= 1'b0;
      start_d1_r <= 1'b0;
    end else begin
      hsync_d1_r <= hsync_s;
      vsync_d1_r <= vsync_s;
      video_d1_r <= video_s;
      image_d1_r <= image_s;
      start_d1_r <= start_s;
    end
  end

  // Stage 2: registered outputs, colour merged with the returned pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
    end else begin
      hsync       <= hsync_d1_r;
      vsync       <= vsync_d1_r;
      video_on    <= video_d1_r;
      frame_start <= start_d1_r;
      vga_r       <= (video_d1_r && image_d1_r && pixel_color) ? 4'hF : 4'h0;
      vga_g       <= (video_d1_r && image_d1_r && pixel_color) ? 4'hF : 4'h0;
      vga_b       <= (video_d1_r && image_d1_r && pixel_color) ? 4'hF : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl with small timing parameters and a
// one-clock-latency memory holding a single lit pixel at (1,0).
module tb_vga_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_color = 1'b0;
  logic [1:0] x_pos;
  logic [1:0] y_pos;
  logic [3:0] bank_counter;
  logic       hsync, vsync, video_on, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_scan_ctrl #(
    .WIDTH(4), .HEIGHT(3),
    .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(2), .WHOLE_LINE(16),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .WHOLE_FRAME(12),
    .SCALE(2), .FRAME_REPEAT(2), .NUM_BANKS(3)
  ) dut (
    .clk(clk), .reset(reset), .pixel_color(pixel_color),
    .x_pos(x_pos), .y_pos(y_pos), .bank_counter(bank_counter),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int due; int x; int y; int bank; } addr_t;
  typedef struct { int due; int hs; int vs; int vo; int fs; int rgb; } out_t;

  addr_t addr_q[$];
  out_t  out_q[$];
  int    n = 0;
  int    total = 0;
  int    bad = 0;

  // hand-derived address traces for one line and one frame
  int xt[16] = '{0,0,1,1,2,2,3,3,3,3,3,3,3,3,3,3};
  int yt[12] = '{0,0,1,1,2,2,2,2,2,2,2,2};

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    end
  endfunction

  // expected values for the position addressed in cycle k
  task automatic push(input int k);
    addr_t a;
    out_t  o;
    int h, ln, fr;
    h  = k % 16;
    ln = (k / 16) % 12;
    fr = k / 192;
    a.due  = k;
    a.x    = xt[h];
    a.y    = yt[ln];
    a.bank = (fr / 2) % 3;
    addr_q.push_back(a);
    o.due = k + 2;
    o.hs  = (h >= 12 && h < 14) ? 1 : 0;
    o.vs  = (ln >= 9 && ln < 11) ? 1 : 0;
    o.vo  = (h < 10 && ln < 8) ? 1 : 0;
    o.rgb = ((h == 2 || h == 3) && ln < 2) ? 15 : 0;
    o.fs  = (h == 0 && ln == 0) ? 1 : 0;
    out_q.push_back(o);
  endtask

  // memory model: one-clock read latency, only pixel (1,0) lit
  initial begin
    logic lit;
    forever begin
      @(negedge clk);
      lit = (x_pos == 2'd1) && (y_pos == 2'd0);
      @(posedge clk);
      #1;
      pixel_color = lit;
    end
  end

  // monitor: pop and compare whatever is due in the current cycle
  initial begin
    addr_t a;
    out_t  o;
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (addr_q.size() > 0 && addr_q[0].due <= n) begin
          a = addr_q.pop_front();
          check("due_addr", a.due, n);
          check("x_pos", x_pos, a.x);
          check("y_pos", y_pos, a.y);
          check("bank_counter", bank_counter, a.bank);
        end
        while (out_q.size() > 0 && out_q[0].due <= n) begin
          o = out_q.pop_front();
          check("due_out", o.due, n);
          check("hsync", hsync, o.hs);
          check("vsync", vsync, o.vs);
          check("video_on", video_on, o.vo);
          check("frame_start", frame_start, o.fs);
          check("vga_r", vga_r, o.rgb);
          check("vga_g", vga_g, o.rgb);
          check("vga_b", vga_b, o.rgb);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_x"}, x_pos, 0);
    check({tag, "_y"}, y_pos, 0);
    check({tag, "_bank"}, bank_counter, 0);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_video"}, video_on, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_r"}, vga_r, 0);
    check({tag, "_g"}, vga_g, 0);
    check({tag, "_b"}, vga_b, 0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    push(0);
  endtask

  task automatic run(input int cnt, input bit do_push);
    repeat (cnt) begin
      @(posedge clk);
      #1;
      n++;
      if (do_push) push(n);
    end
  endtask

  task automatic drain(input string tag);
    run(2, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_addr_left"}, addr_q.size(), 0);
    check({tag, "_out_left"}, out_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");

    // free run: 7 frames of timing, addressing, colour and bank sequence
    release_rst();
    run(7 * 192 + 10, 1'b1);
    drain("run7");

    // reset mid-frame: frame 3, line 3, h=5 is bank 1
    reset = 1'b1;
    #1;
    check_zero("rst_a");
    release_rst();
    run(3 * 192 + 3 * 16 + 5, 1'b1);
    check("bank_before_reset", bank_counter, 1);
    check("x_before_reset", x_pos, 2);
    reset = 1'b1;
    addr_q.delete();
    out_q.delete();
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");

    // restart from (0,0), bank 0, frame_start two clocks later
    release_rst();
    run(400, 1'b1);
    drain("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter WIDTH, default 10: source image width in memory pixels.
REQ-002 Parameter HEIGHT, default 20: source image height in memory pixels.
REQ-003 Parameters H_VISIBLE 800, H_FRONT 40, H_SYNC 128, WHOLE_LINE 1056: horizontal timing in clocks.
REQ-004 Parameters V_VISIBLE 600, V_FRONT 1, V_SYNC 4, WHOLE_FRAME 628: vertical timing in lines.
REQ-005 Parameter SCALE, default 4: pixel replication factor, both axes.
REQ-006 Parameter FRAME_REPEAT, default 2: displayed frames per memory bank.
REQ-007 Parameter NUM_BANKS, default 16: banks cycled, 1..16.
REQ-008 Derived X_ADDRW = $clog2(WIDTH), Y_ADDRW = $clog2(HEIGHT).
REQ-009 One clock; reset is asynchronous and active-high.
REQ-010 clk  in  1  pixel clock.
REQ-011 reset  in  1  asynchronous active-high reset.
REQ-012 pixel_color  in  1  video memory read data, valid one clk after x_pos/y_pos/bank_counter.
REQ-013 x_pos  out  X_ADDRW  memory column address.
REQ-014 y_pos  out  Y_ADDRW  memory row address.
REQ-015 bank_counter  out  4  memory bank select.
REQ-016 hsync  out  1  horizontal sync, active-high.
REQ-017 vsync  out  1  vertical sync, active-high.
REQ-018 video_on  out  1  high during visible area.
REQ-019 vga_r, vga_g, vga_b  out  4 each  colour outputs.
REQ-020 frame_start  out  1  one-cycle pulse aligned with output of position (0,0).

Function
REQ-021 h_cnt counts 0..WHOLE_LINE-1 each clk, wraps to 0; v_cnt increments on h_cnt wrap, counts 0..WHOLE_FRAME-1, wraps to 0.
REQ-022 Raw hsync = H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC; raw vsync likewise with V_ parameters on v_cnt.
REQ-023 Raw video_on = h_cnt < H_VISIBLE and v_cnt < V_VISIBLE; image_on = h_cnt < WIDTH*SCALE and v_cnt < HEIGHT*SCALE.
REQ-024 x_pos, y_pos registered in lockstep with h_cnt/v_cnt: address for counter position P present in the same cycle P is in the counters.
REQ-025 x_pos: sub-counter 0..SCALE-1 advances per clk; on sub-counter = SCALE-1 x_pos increments, saturating at WIDTH-1; both clear to 0 when h_cnt wraps.
REQ-026 y_pos: line sub-counter advances on each h_cnt wrap; on SCALE-1 y_pos increments, saturating at HEIGHT-1; both clear when v_cnt wraps.
REQ-027 No multiplier or divider on the x_pos/y_pos path; scaling by sub-counters only.
REQ-028 Pipeline: position P addressed in cycle t, pixel_color sampled in t+1, all outputs for P registered and visible in t+2; raw hsync/vsync/video_on/image_on delayed by exactly 2 clk.
REQ-029 Colour: delayed image_on and pixel_color=1 -> rgb 4'hF each; otherwise 4'h0; rgb 0 whenever delayed video_on = 0.
REQ-030 frame_cnt counts frames; increments in the cycle h_cnt=WHOLE_LINE-1 and v_cnt=WHOLE_FRAME-1.
REQ-031 When frame_cnt = FRAME_REPEAT-1 at that cycle, frame_cnt clears and bank_counter increments; bank_counter NUM_BANKS-1 wraps to 0.
REQ-032 bank_counter changes only at the frame wrap, never mid-frame.
REQ-033 frame_start high exactly one clk, in the output cycle of position (0,0) (2 clk after counters reach (0,0)).
REQ-034 Elaboration error if WIDTH*SCALE > H_VISIBLE, HEIGHT*SCALE > V_VISIBLE, or NUM_BANKS > 16.

Reset
REQ-035 Asserting reset, at any time, immediately forces all counters, x_pos, y_pos, bank_counter, frame_cnt, pipeline registers to 0; hsync, vsync, video_on, frame_start, rgb read 0.
REQ-036 First clk edge after reset release: counters at (0,0); first frame_start 2 clk later.
REQ-037 Reset mid-frame discards partial frame; scan restarts at (0,0) with bank 0.

Verification (small params: WHOLE_LINE 16, H_VISIBLE 10, H_FRONT 2, H_SYNC 2, WHOLE_FRAME 12, V_VISIBLE 8, V_FRONT 1, V_SYNC 2, WIDTH 4, HEIGHT 3, SCALE 2, FRAME_REPEAT 2, NUM_BANKS 3)
REQ-038 Free-run after reset -> hsync high 2 clk per 16-clk line, starting output cycle of h=12; vsync high lines 9-10; period 192 clk.
REQ-039 Line 0 address trace -> x_pos 0,0,1,1,2,2,3,3 then 3 held to h=15; y_pos 0,0,1,1,2,2 then 2 held across lines.
REQ-040 pixel_color model = memory with pixel(1,0)=1 only -> rgb 4'hF exactly at output cycles for h=2,3 on lines 0,1; 4'h0 elsewhere, including h=8,9 (visible, outside image).
REQ-041 Run 7 frames -> bank_counter 0,0,1,1,2,2,0; changes only at frame wrap; frame_start once per frame.
REQ-042 Assert reset at h=5, v=3 of frame 3 (bank 1) -> all outputs 0 immediately; after release bank_counter 0, frame_start 2 clk later.
